// File: rtl/wb_gc_pkg.sv
// Shared constants and encodings for the framebuffer responder and the display fetcher.
package wb_gc_pkg;

    // Wishbone data and byte-select widths.
    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = 4;

    // Pixel packing inside a framebuffer word: 8 pixels, one 3-bit value per nibble.
    localparam int unsigned PIX_BITS     = 3;
    localparam int unsigned PIX_PER_WORD = 8;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } wb_state_t;

    // Port grant encoding.
    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_GC  = 1'b1
    } grant_t;

endpackage

// File: rtl/video_ram_sp.sv
// Single-port framebuffer RAM: synchronous read, one-cycle latency, per-byte write enables.
// A write returns the word that was stored before the write (read-before-write).
module video_ram_sp
    import wb_gc_pkg::*;
#(
    parameter int unsigned AW = 16
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WB_SW-1:0] we,
    input  logic [AW-1:0]    addr,
    input  logic [WB_DW-1:0] wdata,
    output logic [WB_DW-1:0] rdata
);

    logic [WB_DW-1:0] mem [0:(1 << AW) - 1];

    // Registered read of the old word plus lane-wise write, both gated by en.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int unsigned i = 0; i < WB_SW; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/wb_video_mem_responder.sv
// Wishbone classic slave owning the framebuffer; round-robin shares one RAM
// between the CPU port and the graphic-card fetch port, one word per access.
module wb_video_mem_responder
    import wb_gc_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 65536,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      cpu_adr_i,
    input  logic [WB_DW-1:0] cpu_dat_i,
    input  logic [WB_SW-1:0] cpu_sel_i,
    input  logic             cpu_we_i,
    input  logic             cpu_cyc_i,
    input  logic             cpu_stb_i,
    output logic [WB_DW-1:0] cpu_dat_o,
    output logic             cpu_ack_o,
    input  logic [31:0]      gc_adr_i,
    input  logic [WB_DW-1:0] gc_dat_i,
    input  logic [WB_SW-1:0] gc_sel_i,
    input  logic             gc_we_i,
    input  logic             gc_cyc_i,
    input  logic             gc_stb_i,
    output logic [WB_DW-1:0] gc_dat_o,
    output logic             gc_ack_o
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    wb_state_t state, state_next;
    grant_t    grant, grant_next, last_grant;
    logic      take;

    logic cpu_req, gc_req, granted_req;

    logic [31:0]      req_adr, req_off;
    logic [WB_DW-1:0] req_dat;
    logic [WB_SW-1:0] req_sel;
    logic             req_we, req_in_range;
    logic [AW-1:0]    req_idx;

    logic [AW-1:0]    lat_idx;
    logic [WB_DW-1:0] lat_dat;
    logic [WB_SW-1:0] lat_sel;
    logic             lat_we, lat_in_range;

    logic             ram_en;
    logic [WB_SW-1:0] ram_we;
    logic [WB_DW-1:0] ram_q, read_word;
    logic [WB_DW-1:0] cpu_hold, gc_hold;

    assign cpu_req = cpu_cyc_i & cpu_stb_i;
    assign gc_req  = gc_cyc_i & gc_stb_i;

    // Request status of whichever port currently owns the RAM.
    always_comb begin
        granted_req = (grant == GNT_CPU) ? cpu_req : gc_req;
    end

    // Arbitration and next-state logic.
    always_comb begin
        state_next = state;
        grant_next = grant;
        take       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cpu_req || gc_req) begin
                    take       = 1'b1;
                    state_next = ST_ACCESS;
                    if (cpu_req && gc_req) begin
                        grant_next = (last_grant == GNT_CPU) ? GNT_GC : GNT_CPU;
                    end else if (cpu_req) begin
                        grant_next = GNT_CPU;
                    end else begin
                        grant_next = GNT_GC;
                    end
                end
            end
            ST_ACCESS: state_next = granted_req ? ST_ACK : ST_IDLE;
            ST_ACK:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Select the winning port's request and decode its word index and range.
    always_comb begin
        if (grant_next == GNT_CPU) begin
            req_adr = cpu_adr_i;
            req_dat = cpu_dat_i;
            req_sel = cpu_sel_i;
            req_we  = cpu_we_i;
        end else begin
            req_adr = gc_adr_i;
            req_dat = gc_dat_i;
            req_sel = gc_sel_i;
            req_we  = gc_we_i;
        end
        req_off      = req_adr - BASE_ADDR;
        req_idx      = AW'(req_off >> 2);
        req_in_range = (req_adr >= BASE_ADDR) && ((req_off >> (AW + 2)) == '0);
    end

    // FSM state, grant history and per-port read-data holding registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            grant      <= GNT_GC;
            last_grant <= GNT_GC;
            cpu_hold   <= '0;
            gc_hold    <= '0;
        end else begin
            state <= state_next;
            if (take) begin
                grant      <= grant_next;
                last_grant <= grant_next;
            end
            if (state == ST_ACK) begin
                if (grant == GNT_CPU) begin
                    cpu_hold <= read_word;
                end else begin
                    gc_hold <= read_word;
                end
            end
        end
    end

    // Latch the granted request so the masters may change their bus afterwards.
    always_ff @(posedge clk) begin
        if (take) begin
            lat_idx      <= req_idx;
            lat_dat      <= req_dat;
            lat_sel      <= req_sel;
            lat_we       <= req_we;
            lat_in_range <= req_in_range;
        end
    end

    // RAM is touched only in ACCESS while the owner still requests; reset suppresses it.
    always_comb begin
        ram_en = (state == ST_ACCESS) && granted_req && rst;
        ram_we = (ram_en && lat_we && lat_in_range) ? lat_sel : '0;
    end

    video_ram_sp #(
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (lat_idx),
        .wdata (lat_dat),
        .rdata (ram_q)
    );

    // Out-of-range accesses read as zero.
    always_comb begin
        read_word = lat_in_range ? ram_q : '0;
    end

    // The ACK state is the registered acknowledge; reset masks it within the same cycle
    // so a reset landing in ACK never shows a pulse. Idle ports present their last data.
    always_comb begin
        cpu_ack_o = (state == ST_ACK) && (grant == GNT_CPU) && rst;
        gc_ack_o  = (state == ST_ACK) && (grant == GNT_GC) && rst;
        cpu_dat_o = ((state == ST_ACK) && (grant == GNT_CPU)) ? read_word : cpu_hold;
        gc_dat_o  = ((state == ST_ACK) && (grant == GNT_GC)) ? read_word : gc_hold;
    end

endmodule

// File: tb/tb_wb_video_mem_responder.sv
// Self-checking bench for wb_video_mem_responder: directed scenarios plus randomized
// traffic compared against a word-level behavioural model of the framebuffer.
module tb_wb_video_mem_responder;

    localparam int unsigned MW   = 1024;
    localparam logic [31:0] BASE = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_adr_i, cpu_dat_i, cpu_dat_o;
    logic [3:0]  cpu_sel_i;
    logic        cpu_we_i, cpu_cyc_i, cpu_stb_i, cpu_ack_o;
    logic [31:0] gc_adr_i, gc_dat_i, gc_dat_o;
    logic [3:0]  gc_sel_i;
    logic        gc_we_i, gc_cyc_i, gc_stb_i, gc_ack_o;

    int unsigned cyc_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          both_high = 0;
    int          ack_port_q[$];
    int unsigned ack_cyc_q[$];
    logic [31:0] mdl_mem [int];

    wb_video_mem_responder #(
        .MEM_WORDS (MW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_adr_i (cpu_adr_i),
        .cpu_dat_i (cpu_dat_i),
        .cpu_sel_i (cpu_sel_i),
        .cpu_we_i  (cpu_we_i),
        .cpu_cyc_i (cpu_cyc_i),
        .cpu_stb_i (cpu_stb_i),
        .cpu_dat_o (cpu_dat_o),
        .cpu_ack_o (cpu_ack_o),
        .gc_adr_i  (gc_adr_i),
        .gc_dat_i  (gc_dat_i),
        .gc_sel_i  (gc_sel_i),
        .gc_we_i   (gc_we_i),
        .gc_cyc_i  (gc_cyc_i),
        .gc_stb_i  (gc_stb_i),
        .gc_dat_o  (gc_dat_o),
        .gc_ack_o  (gc_ack_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Ack log used for arbitration ordering; also flags any cycle with both acks high.
    always @(negedge clk) begin
        if (cpu_ack_o && gc_ack_o) both_high++;
        if (cpu_ack_o) begin ack_port_q.push_back(0); ack_cyc_q.push_back(cyc_cnt); end
        if (gc_ack_o)  begin ack_port_q.push_back(1); ack_cyc_q.push_back(cyc_cnt); end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word-level model: out-of-range reads give 0 and writes vanish; in-range accesses
    // return the stored word and then merge the enabled bytes.
    task automatic mdl_access(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                              input bit we, output logic [31:0] exp, output bit known);
        longint unsigned a;
        int              idx;
        logic [31:0]     w;
        a = longint'(adr);
        if (a < longint'(BASE) || a >= longint'(BASE) + 4 * longint'(MW)) begin
            exp   = '0;
            known = 1'b1;
            return;
        end
        idx   = int'((a - longint'(BASE)) / 4);
        known = mdl_mem.exists(idx);
        exp   = known ? mdl_mem[idx] : 32'h0;
        if (we) begin
            if (known) begin
                w = mdl_mem[idx];
                for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
                mdl_mem[idx] = w;
            end else if (sel == 4'hF) begin
                mdl_mem[idx] = dat;
            end
        end
    endtask

    task automatic drive(input bit gc, input bit cyc, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input bit we);
        if (gc) begin
            gc_cyc_i = cyc; gc_stb_i = cyc; gc_adr_i = adr; gc_dat_i = dat; gc_sel_i = sel; gc_we_i = we;
        end else begin
            cpu_cyc_i = cyc; cpu_stb_i = cyc; cpu_adr_i = adr; cpu_dat_i = dat; cpu_sel_i = sel; cpu_we_i = we;
        end
    endtask

    // One classic-cycle transfer; called #1 after a posedge, returns #1 after the drop edge.
    task automatic xfer(input bit gc, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input bit we, output int lat, output logic [31:0] rd);
        int unsigned start;
        bit          acked;
        bit          known;
        logic [31:0] exp;
        start = cyc_cnt;
        acked = 1'b0;
        rd    = '0;
        lat   = -1;
        drive(gc, 1'b1, adr, dat, sel, we);
        for (int i = 0; i < 12 && !acked; i++) begin
            @(negedge clk);
            if (gc ? gc_ack_o : cpu_ack_o) begin
                acked = 1'b1;
                rd    = gc ? gc_dat_o : cpu_dat_o;
                lat   = int'(cyc_cnt - start);
            end
        end
        check(gc ? "gc_ack_seen" : "cpu_ack_seen", 32'(acked), 32'd1);
        if (acked) begin
            mdl_access(adr, dat, sel, we, exp, known);
            if (known) check(gc ? "gc_rdata" : "cpu_rdata", rd, exp);
        end
        @(posedge clk); #1;
        drive(gc, 1'b0, '0, '0, '0, 1'b0);
    endtask

    function automatic logic [31:0] pick_adr();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0:       a = BASE;
            1:       a = BASE + 32'd4;
            2:       a = BASE + 32'h40;
            3:       a = BASE + 32'(4 * (MW / 2));
            4:       a = BASE + 32'(4 * (MW - 1));
            5:       a = BASE + 32'(4 * MW);
            6:       a = BASE - 32'd4;
            default: a = BASE + 32'(4 * MW) + 32'h100;
        endcase
        return a | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat, lat_b, acks;
        logic [31:0] rd, rd_b;

        rst = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_cpu_ack", 32'(cpu_ack_o), 32'd0);
        check("rst_gc_ack", 32'(gc_ack_o), 32'd0);
        check("rst_cpu_dat", cpu_dat_o, 32'h0);
        check("rst_gc_dat", gc_dat_o, 32'h0);
        @(posedge clk); #1;

        // First simultaneous request after reset goes to the CPU.
        ack_port_q.delete(); ack_cyc_q.delete();
        fork
            xfer(1'b0, BASE + 32'd20, 32'h1234_5678, 4'hF, 1'b1, lat, rd);
            xfer(1'b1, BASE + 32'd24, 32'h9ABC_DEF0, 4'hF, 1'b1, lat_b, rd_b);
        join
        check("first_grant", 32'(ack_port_q.size() > 0 ? ack_port_q[0] : 99), 32'd0);

        // Write by CPU then fetch by GC, with base latency.
        xfer(1'b0, BASE + 32'h40, 32'h7654_3210, 4'hF, 1'b1, lat, rd);
        xfer(1'b1, BASE + 32'h40, 32'h0, 4'hF, 1'b0, lat, rd);
        check("gc_read_lat", 32'(lat), 32'd2);
        check("gc_read_data", rd, 32'h7654_3210);

        // Byte lanes.
        xfer(1'b0, BASE, 32'hFFFF_FFFF, 4'hF, 1'b1, lat, rd);
        xfer(1'b0, BASE, 32'h0000_00AA, 4'b0001, 1'b1, lat, rd);
        xfer(1'b1, BASE, 32'h0, 4'hF, 1'b0, lat, rd);
        check("lane_merge", rd, 32'hFFFF_FFAA);

        // Arbitration: both ports back to back, three accesses each.
        ack_port_q.delete(); ack_cyc_q.delete();
        fork
            begin
                for (int i = 0; i < 3; i++) xfer(1'b0, BASE + 32'd4, $urandom, 4'hF, 1'b1, lat, rd);
            end
            begin
                for (int i = 0; i < 3; i++) xfer(1'b1, BASE + 32'h40, 32'h0, 4'hF, 1'b0, lat_b, rd_b);
            end
        join
        check("arb_count", 32'(ack_port_q.size()), 32'd6);
        for (int i = 0; i < ack_port_q.size(); i++) begin
            check("arb_order", 32'(ack_port_q[i]), 32'(i % 2));
            if (i > 0) check("arb_spacing", ack_cyc_q[i] - ack_cyc_q[i-1], 32'd3);
        end

        // Range limits.
        xfer(1'b1, BASE + 32'(4 * MW), 32'h0, 4'hF, 1'b0, lat, rd);
        check("oor_read_zero", rd, 32'h0);
        xfer(1'b0, BASE - 32'd4, 32'hDEAD_BEEF, 4'hF, 1'b1, lat, rd);
        xfer(1'b1, BASE, 32'h0, 4'hF, 1'b0, lat, rd);
        check("oor_write_word0", rd, 32'hFFFF_FFAA);

        // Abort: CPU drops cyc during ACCESS of a write.
        drive(1'b0, 1'b1, BASE + 32'h40, 32'h1111_1111, 4'hF, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        acks = 0;
        repeat (5) begin @(negedge clk); if (cpu_ack_o || gc_ack_o) acks++; end
        check("abort_no_ack", 32'(acks), 32'd0);
        @(posedge clk); #1;
        xfer(1'b1, BASE + 32'h40, 32'h0, 4'hF, 1'b0, lat, rd);
        check("abort_ram_kept", rd, 32'h7654_3210);

        // Reset on the ACCESS edge of a write: write is dropped.
        drive(1'b0, 1'b1, BASE + 32'h40, 32'h2222_2222, 4'hF, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        acks = 0;
        @(negedge clk); if (cpu_ack_o || gc_ack_o) acks++;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk); if (cpu_ack_o || gc_ack_o) acks++;
        check("rstw_no_ack", 32'(acks), 32'd0);
        check("rstw_cpu_dat", cpu_dat_o, 32'h0);
        check("rstw_gc_dat", gc_dat_o, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        xfer(1'b1, BASE + 32'h40, 32'h0, 4'hF, 1'b0, lat, rd);
        check("rstw_ram_kept", rd, 32'h7654_3210);

        // Reset during ACK: no ack pulse, next request served normally.
        drive(1'b1, 1'b1, BASE + 32'h40, 32'h0, 4'hF, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
        acks = 0;
        repeat (3) begin @(negedge clk); if (cpu_ack_o || gc_ack_o) acks++; end
        check("rstack_no_ack", 32'(acks), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        xfer(1'b0, BASE + 32'h40, 32'h0, 4'hF, 1'b0, lat, rd);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_data", rd, 32'h7654_3210);

        // Randomized single-port traffic; every in-range pool word is seeded first.
        xfer(1'b0, BASE + 32'(4 * (MW / 2)), $urandom, 4'hF, 1'b1, lat, rd);
        xfer(1'b1, BASE + 32'(4 * (MW - 1)), $urandom, 4'hF, 1'b1, lat, rd);
        for (int i = 0; i < 60; i++) begin
            xfer(1'($urandom_range(0, 1)), pick_adr(), $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), lat, rd);
            check("rand_lat", 32'(lat), 32'd2);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        // Randomized contention: both ports at once, model updated in ack order.
        for (int i = 0; i < 15; i++) begin
            fork
                xfer(1'b0, pick_adr(), $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), lat, rd);
                xfer(1'b1, pick_adr(), $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), lat_b, rd_b);
            join
        end

        check("both_ack_high", 32'(both_high), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
